// File: rtl/cci_mpf_prim_pkg.sv
// Shared helpers for the MPF primitive library.
package cci_mpf_prim_pkg;

  // Address width for an N-deep structure, never narrower than one bit.
  function automatic int ptr_width(input int n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/cci_mpf_prim_fifo_n_mem.sv
// FIFO storage: one synchronous write port, one asynchronous read port.
module cci_mpf_prim_fifo_n_mem
  import cci_mpf_prim_pkg::*;
#(
  parameter int N_DATA_BITS = 32,
  parameter int N_ENTRIES   = 4,
  parameter int N_ADDR_BITS = ptr_width(N_ENTRIES)
)
(
  input  logic                   clk,
  input  logic                   wen,
  input  logic [N_ADDR_BITS-1:0] waddr,
  input  logic [N_DATA_BITS-1:0] wdata,
  input  logic [N_ADDR_BITS-1:0] raddr,
  output logic [N_DATA_BITS-1:0] rdata
);

  logic [N_DATA_BITS-1:0] mem_q [N_ENTRIES];

  // Storage write; contents are deliberately not reset.
  always_ff @(posedge clk) begin
    if (wen) begin
      mem_q[waddr] <= wdata;
    end
  end

  assign rdata = mem_q[raddr];

endmodule

// File: rtl/cci_mpf_prim_fifo_n.sv
// Parametrised N-entry FIFO with show-ahead read, occupancy count and
// programmable almostFull threshold.
module cci_mpf_prim_fifo_n
  import cci_mpf_prim_pkg::*;
#(
  parameter int N_DATA_BITS = 32,
  parameter int N_ENTRIES   = 4,
  parameter int THRESHOLD   = 1
)
(
  input  logic                      clk,
  input  logic                      reset,
  input  logic [N_DATA_BITS-1:0]    enq_data,
  input  logic                      enq_en,
  output logic                      notFull,
  output logic                      almostFull,
  output logic [N_DATA_BITS-1:0]    first,
  input  logic                      deq_en,
  output logic                      notEmpty,
  output logic [$clog2(N_ENTRIES):0] count
);

  localparam int PTR_W = ptr_width(N_ENTRIES);
  localparam int CNT_W = PTR_W + 1;

  if (N_ENTRIES < 2 || (N_ENTRIES & (N_ENTRIES - 1)) != 0) begin : g_bad_depth
    $error("cci_mpf_prim_fifo_n: N_ENTRIES must be a power of 2 and >= 2");
  end
  if (THRESHOLD < 0 || THRESHOLD >= N_ENTRIES) begin : g_bad_threshold
    $error("cci_mpf_prim_fifo_n: THRESHOLD must be in 0..N_ENTRIES-1");
  end

  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             enq_ok_s;
  logic             deq_ok_s;

  // Illegal strobes are squashed so a protocol error cannot corrupt state.
  assign enq_ok_s = enq_en & notFull;
  assign deq_ok_s = deq_en & notEmpty;

  // Next-state for pointers and occupancy.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    cnt_d    = cnt_q;
    if (enq_ok_s) begin
      wr_ptr_d = wr_ptr_q + PTR_W'(1);
    end else begin
      wr_ptr_d = wr_ptr_q;
    end
    if (deq_ok_s) begin
      rd_ptr_d = rd_ptr_q + PTR_W'(1);
    end else begin
      rd_ptr_d = rd_ptr_q;
    end
    case ({enq_ok_s, deq_ok_s})
      2'b10:   cnt_d = cnt_q + CNT_W'(1);
      2'b01:   cnt_d = cnt_q - CNT_W'(1);
      default: cnt_d = cnt_q;
    endcase
  end

  // State registers; reset wins over any same-cycle strobe.
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q    <= cnt_d;
    end
  end

  assign notEmpty   = (cnt_q != CNT_W'(0));
  assign notFull    = (cnt_q != CNT_W'(N_ENTRIES));
  assign almostFull = ((CNT_W'(N_ENTRIES) - cnt_q) <= CNT_W'(THRESHOLD));
  assign count      = cnt_q;

  cci_mpf_prim_fifo_n_mem #(
    .N_DATA_BITS (N_DATA_BITS),
    .N_ENTRIES   (N_ENTRIES),
    .N_ADDR_BITS (PTR_W)
  ) u_mem (
    .clk   (clk),
    .wen   (enq_ok_s),
    .waddr (wr_ptr_q),
    .wdata (enq_data),
    .raddr (rd_ptr_q),
    .rdata (first)
  );

  // Protocol checks, masked while reset is asserted.
  always_ff @(posedge clk) begin
    if (!reset) begin
      assert (!(enq_en && !notFull)) else $fatal(1, "Can't ENQ when full!");
      assert (!(deq_en && !notEmpty)) else $fatal(1, "Can't DEQ when empty!");
    end
  end

endmodule
